game_state_ctrl: RTL and testbench

//  Top-level game flow FSM. Consumes the start/restart click pulse from the menu button renderer
//  and drives game_active (0=menu, 1=playing, 2=game over) back to it. Sequences the round reset,
//  end-of-round delay and win/loss result. Tracks elapsed round time in seconds.

---
 rtl/game_state_ctrl.sv | 167 ++++++++++++++++
 tb/tb_game_state_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game flow controller: menu -> round reset -> play -> end-of-round delay -> game over,
// with win/loss result and an elapsed-seconds timer driven by vsync frame ticks.
module game_state_ctrl #(
   parameter int RESET_CYCLES     = 16,
   parameter int FRAMES_PER_SEC   = 60,
   parameter int END_DELAY_FRAMES = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_start,
   input  logic       remote_start,
   input  logic       vsync,
   input  logic       player_dead,
   input  logic       player_2_dead,
   input  logic       player_2_data_valid,
   input  logic       boss_dead,
   output logic [1:0] game_active,
   output logic       round_reset,
   output logic       player_won,
   output logic [7:0] elapsed_s
);

   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int FW = $clog2(FRAMES_PER_SEC + 1);
   localparam int EW = $clog2(END_DELAY_FRAMES + 1);

   localparam logic [RW-1:0] R_LAST = RW'(RESET_CYCLES - 1);
   localparam logic [RW-1:0] R_ONE  = RW'(1);
   localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_SEC - 1);
   localparam logic [FW-1:0] F_ONE  = FW'(1);
   localparam logic [EW-1:0] E_LAST = EW'(END_DELAY_FRAMES - 1);
   localparam logic [EW-1:0] E_ONE  = EW'(1);

   typedef enum logic [2:0] {
      S_MENU   = 3'd0,
      S_RESET  = 3'd1,
      S_PLAY   = 3'd2,
      S_ENDING = 3'd3,
      S_OVER   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] reset_cnt_q, reset_cnt_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [EW-1:0] end_cnt_q, end_cnt_d;
   logic          vsync_q;
   logic [1:0]    game_active_q, game_active_d;
   logic          round_reset_q, round_reset_d;
   logic          player_won_q, player_won_d;
   logic [7:0]    elapsed_s_q, elapsed_s_d;
   logic          frame_tick_s, start_s, loss_s;

   // Next-state, counter and output computation for the game flow.
   always_comb begin
      frame_tick_s  = vsync & ~vsync_q;
      start_s       = game_start | remote_start;
      loss_s        = player_dead | (player_2_data_valid & player_2_dead);
      state_d       = state_q;
      reset_cnt_d   = reset_cnt_q;
      frame_cnt_d   = frame_cnt_q;
      end_cnt_d     = end_cnt_q;
      player_won_d  = player_won_q;
      elapsed_s_d   = elapsed_s_q;
      game_active_d = 2'd0;
      round_reset_d = 1'b0;

      case (state_q)
         S_MENU, S_OVER: begin
            if (start_s) begin
               state_d      = S_RESET;
               reset_cnt_d  = {RW{1'b0}};
               frame_cnt_d  = {FW{1'b0}};
               elapsed_s_d  = 8'd0;
               player_won_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_RESET: begin
            if (reset_cnt_q == R_LAST) begin
               state_d     = S_PLAY;
               reset_cnt_d = {RW{1'b0}};
            end else begin
               reset_cnt_d = reset_cnt_q + R_ONE;
            end
         end
         S_PLAY: begin
            if (frame_tick_s) begin
               if (frame_cnt_q == F_LAST) begin
                  frame_cnt_d = {FW{1'b0}};
                  elapsed_s_d = (elapsed_s_q == 8'hFF) ? 8'hFF : elapsed_s_q + 8'd1;
               end else begin
                  frame_cnt_d = frame_cnt_q + F_ONE;
               end
            end else begin
               frame_cnt_d = frame_cnt_q;
            end
            // Loss wins over a simultaneous boss kill.
            if (loss_s) begin
               state_d      = S_ENDING;
               end_cnt_d    = {EW{1'b0}};
               player_won_d = 1'b0;
            end else if (boss_dead) begin
               state_d      = S_ENDING;
               end_cnt_d    = {EW{1'b0}};
               player_won_d = 1'b1;
            end else begin
               state_d = S_PLAY;
            end
         end
         S_ENDING: begin
            if (frame_tick_s) begin
               if (end_cnt_q == E_LAST) begin
                  state_d   = S_OVER;
                  end_cnt_d = {EW{1'b0}};
               end else begin
                  end_cnt_d = end_cnt_q + E_ONE;
               end
            end else begin
               end_cnt_d = end_cnt_q;
            end
         end
         default: begin
            state_d = S_MENU;
         end
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      case (state_d)
         S_MENU:  game_active_d = 2'd0;
         S_OVER:  game_active_d = 2'd2;
         default: game_active_d = 2'd1;
      endcase
      round_reset_d = (state_d == S_RESET);
   end

   // State, counters, vsync edge history and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_MENU;
         reset_cnt_q   <= {RW{1'b0}};
         frame_cnt_q   <= {FW{1'b0}};
         end_cnt_q     <= {EW{1'b0}};
         vsync_q       <= 1'b0;
         game_active_q <= 2'd0;
         round_reset_q <= 1'b0;
         player_won_q  <= 1'b0;
         elapsed_s_q   <= 8'd0;
      end else begin
         state_q       <= state_d;
         reset_cnt_q   <= reset_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         end_cnt_q     <= end_cnt_d;
         vsync_q       <= vsync;
         game_active_q <= game_active_d;
         round_reset_q <= round_reset_d;
         player_won_q  <= player_won_d;
         elapsed_s_q   <= elapsed_s_d;
      end
   end

   assign game_active = game_active_q;
   assign round_reset = round_reset_q;
   assign player_won  = player_won_q;
   assign elapsed_s   = elapsed_s_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: a table of round-flow vectors with hand-computed
// expectations, plus hand sequences for reset, the round_reset window and async reset.
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       game_start, remote_start, vsync;
   logic       player_dead, player_2_dead, player_2_data_valid, boss_dead;
   logic [1:0] game_active;
   logic       round_reset, player_won;
   logic [7:0] elapsed_s;

   int n_vec = 0;
   int n_bad = 0;

   game_state_ctrl dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .game_start          (game_start),
      .remote_start        (remote_start),
      .vsync               (vsync),
      .player_dead         (player_dead),
      .player_2_dead       (player_2_dead),
      .player_2_data_valid (player_2_data_valid),
      .boss_dead           (boss_dead),
      .game_active         (game_active),
      .round_reset         (round_reset),
      .player_won          (player_won),
      .elapsed_s           (elapsed_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         waits;
      int         ticks;
      logic       gs, rs, pd, p2d, p2v, bd;
      logic [1:0] ga;
      logic       rr, won;
      logic [7:0] el;
      string      name;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int waits, input int ticks,
                               input logic gs, input logic rs, input logic pd,
                               input logic p2d, input logic p2v, input logic bd,
                               input logic [1:0] ga, input logic rr, input logic won,
                               input logic [7:0] el, input string name);
      vec_t v;
      v.waits = waits; v.ticks = ticks;
      v.gs = gs; v.rs = rs; v.pd = pd; v.p2d = p2d; v.p2v = p2v; v.bd = bd;
      v.ga = ga; v.rr = rr; v.won = won; v.el = el; v.name = name;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string nm, input logic [1:0] ega, input logic err,
                        input logic ewon, input logic [7:0] eel);
      n_vec++;
      if (game_active !== ega || round_reset !== err || player_won !== ewon || elapsed_s !== eel) begin
         n_bad++;
         $display("FAIL %s: got ga=%0d rr=%0b won=%0b el=%0d, expected ga=%0d rr=%0b won=%0b el=%0d",
                  nm, game_active, round_reset, player_won, elapsed_s, ega, err, ewon, eel);
      end
   endtask

   task automatic clear_inputs();
      game_start = 1'b0; remote_start = 1'b0; vsync = 1'b0;
      player_dead = 1'b0; player_2_dead = 1'b0; player_2_data_valid = 1'b0; boss_dead = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      game_start = 1'b0; remote_start = 1'b0; vsync = 1'b0;
      player_dead = v.pd; player_2_dead = v.p2d; player_2_data_valid = v.p2v; boss_dead = v.bd;
      for (int i = 0; i < v.waits; i++) step();
      for (int i = 0; i < v.ticks; i++) begin
         vsync = 1'b1; step();
         vsync = 1'b0; step();
      end
      game_start = v.gs; remote_start = v.rs;
      step();
      check(v.name, v.ga, v.rr, v.won, v.el);
      game_start = 1'b0; remote_start = 1'b0;
   endtask

   initial begin
      //             waits ticks   gs rs pd p2d p2v bd   ga rr won el
      tbl.push_back(mk(0, 130,     0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd2,   "timer_130_ticks"));
      tbl.push_back(mk(0, 0,       0, 0, 0, 1, 0, 0,   2'd1, 0, 0, 8'd2,   "p2_dead_invalid"));
      tbl.push_back(mk(0, 50,      0, 0, 0, 1, 0, 0,   2'd1, 0, 0, 8'd3,   "p2_invalid_still_play"));
      tbl.push_back(mk(0, 0,       0, 0, 0, 1, 1, 0,   2'd1, 0, 0, 8'd3,   "p2_valid_loss"));
      tbl.push_back(mk(0, 119,     0, 0, 1, 0, 0, 1,   2'd1, 0, 0, 8'd3,   "ending_119_frozen"));
      tbl.push_back(mk(0, 1,       0, 0, 0, 0, 0, 0,   2'd2, 0, 0, 8'd3,   "over_after_120"));
      tbl.push_back(mk(3, 0,       0, 0, 0, 0, 0, 0,   2'd2, 0, 0, 8'd3,   "over_hold"));
      tbl.push_back(mk(0, 0,       0, 1, 0, 0, 0, 0,   2'd1, 1, 0, 8'd0,   "remote_restart"));
      tbl.push_back(mk(15, 0,      0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd0,   "round2_play"));
      tbl.push_back(mk(0, 0,       1, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd0,   "start_ignored_play"));
      tbl.push_back(mk(0, 0,       0, 0, 0, 0, 0, 1,   2'd1, 0, 1, 8'd0,   "boss_win"));
      tbl.push_back(mk(0, 0,       1, 1, 0, 0, 0, 0,   2'd1, 0, 1, 8'd0,   "start_ignored_ending"));
      tbl.push_back(mk(0, 120,     0, 0, 0, 0, 0, 0,   2'd2, 0, 1, 8'd0,   "win_over"));
      tbl.push_back(mk(0, 0,       1, 1, 0, 0, 0, 0,   2'd1, 1, 0, 8'd0,   "dual_start"));
      tbl.push_back(mk(15, 0,      0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd0,   "round3_play"));
      tbl.push_back(mk(0, 15300,   0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd255, "timer_255"));
      tbl.push_back(mk(0, 60,      0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd255, "timer_saturate"));
      tbl.push_back(mk(0, 0,       0, 0, 1, 0, 0, 1,   2'd1, 0, 0, 8'd255, "loss_priority"));
      tbl.push_back(mk(0, 120,     0, 0, 0, 0, 0, 0,   2'd2, 0, 0, 8'd255, "loss_over"));
      tbl.push_back(mk(0, 0,       1, 0, 0, 0, 0, 0,   2'd1, 1, 0, 8'd0,   "restart4"));
      tbl.push_back(mk(15, 0,      0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd0,   "round4_play"));
      tbl.push_back(mk(0, 70,      0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 8'd1,   "round4_timer"));

      // Reset held with random inputs.
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         game_start = 1'($urandom); remote_start = 1'($urandom); vsync = 1'($urandom);
         player_dead = 1'($urandom); player_2_dead = 1'($urandom);
         player_2_data_valid = 1'($urandom); boss_dead = 1'($urandom);
         step();
         check("reset_hold", 2'd0, 1'b0, 1'b0, 8'd0);
      end
      clear_inputs();
      rst_n = 1'b1;
      step();
      check("menu_idle_1", 2'd0, 1'b0, 1'b0, 8'd0);
      step();
      check("menu_idle_2", 2'd0, 1'b0, 1'b0, 8'd0);

      // Start pulse: round_reset for exactly 16 cycles; a second start inside RESET is ignored.
      game_start = 1'b1;
      step();
      game_start = 1'b0;
      check("rr_cycle_1", 2'd1, 1'b1, 1'b0, 8'd0);
      for (int i = 2; i <= 16; i++) begin
         game_start = (i == 3);
         step();
         game_start = 1'b0;
         check($sformatf("rr_cycle_%0d", i), 2'd1, 1'b1, 1'b0, 8'd0);
      end
      step();
      check("play_entry", 2'd1, 1'b0, 1'b0, 8'd0);

      foreach (tbl[k]) apply(tbl[k]);

      // Async reset mid-PLAY, away from any clock edge.
      #2 rst_n = 1'b0;
      #1 check("async_reset", 2'd0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      step();
      check("menu_after_async", 2'd0, 1'b0, 1'b0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
